// File: rtl/stage_ex_mdu_pkg.sv
// Shared types and helpers for the EX-stage multiply/divide unit.
package stage_ex_mdu_pkg;

  // Operation encoding matches the RV32M funct3 field.
  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } mdu_state_t;

  // Decoded control word. mdu_en steers an instruction to this unit
  // instead of the single-cycle ALU.
  typedef struct packed {
    logic alu_en;
    logic mdu_en;
    logic mem_rd;
    logic mem_wr;
    logic reg_wr;
  } control_signal_t;

  // rs1 is treated as two's complement for these operations.
  function automatic logic op_signed_a(input mdu_op_t op);
    return (op == MDU_MULH) || (op == MDU_MULHSU) ||
           (op == MDU_DIV)  || (op == MDU_REM);
  endfunction

  // rs2 is treated as two's complement for these operations.
  function automatic logic op_signed_b(input mdu_op_t op);
    return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  function automatic logic op_is_rem(input mdu_op_t op);
    return (op == MDU_REM) || (op == MDU_REMU);
  endfunction

endpackage

// File: rtl/stage_ex_mdu_if.sv
// Request/response bundle between the EX stage and the MDU.
interface stage_ex_mdu_if
  import stage_ex_mdu_pkg::*;
#(
  parameter int XLEN = 32
) ();

  logic            req_e;
  mdu_op_t         op_e;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            flush_e;
  logic            stall_mdu;
  logic            done_e;
  logic [XLEN-1:0] mduresult_e;

  // EX stage side: issues operations, consumes stall and result.
  modport master (
    output req_e, op_e, in_a, in_b, flush_e,
    input  stall_mdu, done_e, mduresult_e
  );

  // MDU side.
  modport slave (
    input  req_e, op_e, in_a, in_b, flush_e,
    output stall_mdu, done_e, mduresult_e
  );

endinterface

// File: rtl/stage_ex_mdu_div_step.sv
// DIV_STEP restoring-division iterations on the {remainder, quotient} pair.
// The quotient register starts out holding the dividend and is shifted out
// MSB-first while quotient bits are shifted in at the bottom.
module stage_ex_mdu_div_step #(
  parameter int XLEN     = 32,
  parameter int DIV_STEP = 1
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0]   trial;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quo;

  // Unrolled shift/compare/subtract chain.
  always_comb begin
    trial = '0;
    rem   = rem_i;
    quo   = quo_i;
    for (int i = 0; i < DIV_STEP; i++) begin
      trial = {rem, quo[XLEN-1]};
      quo   = {quo[XLEN-2:0], 1'b0};
      if (trial >= {1'b0, divisor_i}) begin
        trial  = trial - {1'b0, divisor_i};
        quo[0] = 1'b1;
      end
      rem = trial[XLEN-1:0];
    end
    rem_o = rem;
    quo_o = quo;
  end

endmodule

// File: rtl/stage_ex_mdu.sv
// Iterative RV32M multiply/divide unit beside the EX-stage ALU.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for req_e; corner-case divides resolve straight to DONE
// MUL    | shift-add on operand magnitudes, MUL_STEP bits per cycle
// DIV    | restoring divide on operand magnitudes, DIV_STEP bits per cycle
// FIX    | apply result signs, pick the requested half/quotient/remainder
// DONE   | result on mduresult_e with a one-cycle done_e
//
// Datapath sharing: acc_q is the 2*XLEN product accumulator during MUL and
// the {remainder, quotient} pair during DIV; opb_q holds the multiplicand
// or the divisor magnitude.
module stage_ex_mdu
  import stage_ex_mdu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1,
  parameter int DIV_STEP = 1
) (
  input  logic          clk,
  input  logic          start,
  stage_ex_mdu_if.slave bus
);

  if (XLEN % MUL_STEP != 0) begin : g_bad_mul_step
    $error("stage_ex_mdu: XLEN must be a multiple of MUL_STEP");
  end
  if (XLEN % DIV_STEP != 0) begin : g_bad_div_step
    $error("stage_ex_mdu: XLEN must be a multiple of DIV_STEP");
  end

  localparam int MUL_ITERS = XLEN / MUL_STEP;
  localparam int DIV_ITERS = XLEN / DIV_STEP;
  localparam int MIN_STEP  = (MUL_STEP < DIV_STEP) ? MUL_STEP : DIV_STEP;
  localparam int CNT_W     = $clog2(XLEN / MIN_STEP + 1);

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_ITERS - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_ITERS - 1);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  ALL_ONES = '1;

  mdu_state_t        state_q, state_d;
  mdu_op_t           op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              stall;
  mdu_op_t           op_in;
  logic [2:0]        op_raw;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_by_zero, div_ovf;
  logic [2*XLEN:0]   mul_t;
  logic [XLEN-1:0]   div_rem, div_quo;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo_s, rem_s, fix_result;

  assign op_in  = bus.op_e;
  assign op_raw = bus.op_e;

  // Incoming operand signs and magnitudes.
  assign a_neg = op_signed_a(op_in) & bus.in_a[XLEN-1];
  assign b_neg = op_signed_b(op_in) & bus.in_b[XLEN-1];
  assign a_mag = a_neg ? -bus.in_a : bus.in_a;
  assign b_mag = b_neg ? -bus.in_b : bus.in_b;

  // Divides whose results are fixed by the ISA and skip iteration.
  assign div_by_zero = op_raw[2] & (bus.in_b == '0);
  assign div_ovf     = op_raw[2] & ~op_raw[0] &
                       (bus.in_a == INT_MIN) & (bus.in_b == ALL_ONES);

  // MUL_STEP shift-add iterations; the extra top bit catches the add carry.
  always_comb begin
    mul_t = {1'b0, acc_q};
    for (int i = 0; i < MUL_STEP; i++) begin
      if (mul_t[0]) begin
        mul_t[2*XLEN:XLEN] = mul_t[2*XLEN:XLEN] + {1'b0, opb_q};
      end
      mul_t = mul_t >> 1;
    end
  end

  stage_ex_mdu_div_step #(
    .XLEN     (XLEN),
    .DIV_STEP (DIV_STEP)
  ) u_div_step (
    .rem_i     (acc_q[2*XLEN-1:XLEN]),
    .quo_i     (acc_q[XLEN-1:0]),
    .divisor_i (opb_q),
    .rem_o     (div_rem),
    .quo_o     (div_quo)
  );

  // Sign fix-up and result selection for the FIX state.
  always_comb begin
    prod  = neg_res_q ? -acc_q : acc_q;
    quo_s = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_s = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (op_q == MDU_MUL) begin
      fix_result = prod[XLEN-1:0];
    end else if (op_q == MDU_MULH || op_q == MDU_MULHSU || op_q == MDU_MULHU) begin
      fix_result = prod[2*XLEN-1:XLEN];
    end else if (op_is_rem(op_q)) begin
      fix_result = rem_s;
    end else begin
      fix_result = quo_s;
    end
  end

  // Next-state, datapath updates and stall; flush overrides everything.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    stall     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_e && !bus.flush_e) begin
          stall     = 1'b1;
          op_d      = op_in;
          cnt_d     = '0;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          if (div_by_zero) begin
            result_d = op_raw[1] ? bus.in_a : ALL_ONES;
            state_d  = S_DONE;
          end else if (div_ovf) begin
            result_d = op_raw[1] ? '0 : INT_MIN;
            state_d  = S_DONE;
          end else if (op_raw[2]) begin
            opb_d   = b_mag;
            acc_d   = {{XLEN{1'b0}}, a_mag};
            state_d = S_DIV;
          end else begin
            opb_d   = a_mag;
            acc_d   = {{XLEN{1'b0}}, b_mag};
            state_d = S_MUL;
          end
        end
      end
      S_MUL: begin
        stall = 1'b1;
        acc_d = mul_t[2*XLEN-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == MUL_LAST) state_d = S_FIX;
      end
      S_DIV: begin
        stall = 1'b1;
        acc_d = {div_rem, div_quo};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DIV_LAST) state_d = S_FIX;
      end
      S_FIX: begin
        stall    = 1'b1;
        result_d = fix_result;
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (bus.flush_e) begin
      state_d = S_IDLE;
      stall   = 1'b0;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!start) begin
      state_q   <= S_IDLE;
      op_q      <= MDU_MUL;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign bus.stall_mdu   = stall;
  assign bus.done_e      = (state_q == S_DONE);
  assign bus.mduresult_e = (state_q == S_DONE) ? result_q : '0;

endmodule

// File: tb/tb_stage_ex_mdu.sv
// Bench for stage_ex_mdu: two instances (1/1 and 4/2 bits per cycle) see the
// same stimulus and are checked against an arithmetic RV32M model.
module tb_stage_ex_mdu;
  import stage_ex_mdu_pkg::*;

  localparam int XLEN = 32;

  logic        clk   = 1'b0;
  logic        start = 1'b0;
  logic        req   = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op    = 3'b000;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;

  int n_checks = 0;
  int n_pass   = 0;

  stage_ex_mdu_if #(.XLEN(XLEN)) bus_a ();
  stage_ex_mdu_if #(.XLEN(XLEN)) bus_b ();

  assign bus_a.req_e   = req;
  assign bus_a.op_e    = mdu_op_t'(op);
  assign bus_a.in_a    = a;
  assign bus_a.in_b    = b;
  assign bus_a.flush_e = flush;
  assign bus_b.req_e   = req;
  assign bus_b.op_e    = mdu_op_t'(op);
  assign bus_b.in_a    = a;
  assign bus_b.in_b    = b;
  assign bus_b.flush_e = flush;

  stage_ex_mdu #(.XLEN(XLEN), .MUL_STEP(1), .DIV_STEP(1)) dut_a (
    .clk   (clk),
    .start (start),
    .bus   (bus_a)
  );

  stage_ex_mdu #(.XLEN(XLEN), .MUL_STEP(4), .DIV_STEP(2)) dut_b (
    .clk   (clk),
    .start (start),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // RV32M semantics written directly with 64-bit integer arithmetic.
  function automatic logic [31:0] ref_mdu(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux, uy, p;
    logic [63:0] pb;
    sx = longint'(signed'(x));
    sy = longint'(signed'(y));
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    case (o)
      3'b000: begin p = sx * sy; pb = p; return pb[31:0]; end
      3'b001: begin p = sx * sy; pb = p; return pb[63:32]; end
      3'b010: begin p = sx * uy; pb = p; return pb[63:32]; end
      3'b011: begin p = ux * uy; pb = p; return pb[63:32]; end
      3'b100: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sx / sy; pb = p; return pb[31:0];
      end
      3'b101: begin
        if (y == 0) return 32'hFFFF_FFFF;
        p = ux / uy; pb = p; return pb[31:0];
      end
      3'b110: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        p = sx % sy; pb = p; return pb[31:0];
      end
      default: begin
        if (y == 0) return x;
        p = ux % uy; pb = p; return pb[31:0];
      end
    endcase
  endfunction

  // Cycle (request cycle = 0) in which done_e is expected.
  function automatic int ref_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                 input int ms, input int ds);
    if (o[2] && (y == 0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) return 1;
    return (o[2] ? XLEN / ds : XLEN / ms) + 2;
  endfunction

  // Issue one operation, optionally flush in cycle flush_cyc or reset in
  // cycle rst_cyc (-1 = none), and check both instances cycle by cycle.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int flush_cyc, input int rst_cyc);
    logic [31:0] exp_res;
    logic [31:0] res_a, res_b;
    int lat_a, lat_b, kill, stop;
    int done_a, done_b, bad_a, bad_b;
    logic es_a, es_b, ed_a, ed_b;
    exp_res = ref_mdu(o, x, y);
    lat_a   = ref_lat(o, x, y, 1, 1);
    lat_b   = ref_lat(o, x, y, 4, 2);
    kill    = -1;
    if (flush_cyc >= 0) kill = flush_cyc;
    else if (rst_cyc >= 0) kill = rst_cyc + 1;
    stop   = (kill >= 0) ? kill : ((lat_a > lat_b) ? lat_a : lat_b);
    done_a = -1; done_b = -1; bad_a = 0; bad_b = 0;
    res_a  = '0; res_b = '0;
    for (int cyc = 0; cyc <= stop; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 0) begin
        req = 1'b1; op = o; a = x; b = y;
      end else begin
        req = 1'b0; op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
      end
      flush = (cyc == flush_cyc);
      start = (cyc != rst_cyc);
      @(negedge clk);
      es_a = (cyc < lat_a) && !(kill >= 0 && cyc >= kill);
      es_b = (cyc < lat_b) && !(kill >= 0 && cyc >= kill);
      ed_a = (cyc == lat_a) && !(kill >= 0 && cyc >= kill);
      ed_b = (cyc == lat_b) && !(kill >= 0 && cyc >= kill);
      if (bus_a.stall_mdu !== es_a) bad_a++;
      if (bus_b.stall_mdu !== es_b) bad_b++;
      if (bus_a.done_e !== ed_a) bad_a++;
      if (bus_b.done_e !== ed_b) bad_b++;
      if (bus_a.done_e === 1'b1) begin
        if (done_a < 0) begin done_a = cyc; res_a = bus_a.mduresult_e; end
      end else if (bus_a.mduresult_e !== '0) bad_a++;
      if (bus_b.done_e === 1'b1) begin
        if (done_b < 0) begin done_b = cyc; res_b = bus_b.mduresult_e; end
      end else if (bus_b.mduresult_e !== '0) bad_b++;
    end
    if (kill < 0) begin
      chk({tag, ".lat_a"}, 32'(done_a), 32'(lat_a));
      chk({tag, ".res_a"}, res_a, exp_res);
      chk({tag, ".lat_b"}, 32'(done_b), 32'(lat_b));
      chk({tag, ".res_b"}, res_b, exp_res);
    end else begin
      chk({tag, ".nodone_a"}, 32'(done_a), 32'hFFFF_FFFF);
      chk({tag, ".nodone_b"}, 32'(done_b), 32'hFFFF_FFFF);
    end
    chk({tag, ".profile_a"}, 32'(bad_a), 32'd0);
    chk({tag, ".profile_b"}, 32'(bad_b), 32'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.stall_a", 32'(bus_a.stall_mdu), 32'd0);
    chk("rst.done_a",  32'(bus_a.done_e), 32'd0);
    chk("rst.res_a",   bus_a.mduresult_e, 32'd0);
    chk("rst.stall_b", 32'(bus_b.stall_mdu), 32'd0);
    chk("rst.done_b",  32'(bus_b.done_e), 32'd0);
    chk("rst.res_b",   bus_b.mduresult_e, 32'd0);
    @(posedge clk);
    #1 start = 1'b1;

    run_op("mul",     3'b000, 32'd7,          32'hFFFF_FFFD, -1, -1);
    run_op("mulh",    3'b001, 32'h8000_0000, 32'h8000_0000, -1, -1);
    run_op("mulhsu",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
    run_op("mulhu",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
    run_op("div",     3'b100, 32'hFFFF_FFF9, 32'd2,         -1, -1);
    run_op("rem",     3'b110, 32'hFFFF_FFF9, 32'd2,         -1, -1);
    run_op("divu",    3'b101, 32'd100,       32'd7,         -1, -1);
    run_op("remu",    3'b111, 32'd100,       32'd7,         -1, -1);
    run_op("div0",    3'b100, 32'd5,         32'd0,         -1, -1);
    run_op("remu0",   3'b111, 32'd5,         32'd0,         -1, -1);
    run_op("divovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
    run_op("removf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
    run_op("flush",   3'b100, 32'd1000,      32'd3,         10, -1);
    run_op("mul34",   3'b000, 32'd3,         32'd4,         -1, -1);
    run_op("reset",   3'b000, 32'd9,         32'd9,         -1, 5);
    run_op("postrst", 3'b011, 32'h1234_5678, 32'h9ABC_DEF0, -1, -1);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  ro;
      logic [31:0] rx, ry;
      ro = 3'($urandom_range(0, 7));
      rx = pick_operand();
      ry = pick_operand();
      run_op($sformatf("rnd%0d", i), ro, rx, ry, -1, -1);
    end

    @(posedge clk);
    #1;
    flush = 1'b0;
    start = 1'b1;
    req   = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
